load_store_unit: RTL

//  Memory-stage adapter between the RISC-V core datapath and the word-wide DataMem.

---
 rtl/load_store_unit.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-stage adapter between the RISC-V core datapath and the word-wide
//   DataMem. It takes one load/store request at a time and sizes it to a byte,
//   halfword or word. It checks alignment, address range and funct3 legality.
//   Sub-word stores are done as a read-modify-write. Load data is sign- or
//   zero-extended before it is returned.
//
// Ports
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   req_valid/ready     request handshake; ready only while idle
//   req_we              1 = store, 0 = load
//   req_funct3          RV32I size/sign code (LB LH LW LBU LHU / SB SH SW)
//   req_addr            byte address
//   req_wdata           right-aligned store data
//   rsp_valid           one-cycle response pulse per accepted request
//   rsp_err             misaligned, out-of-range or illegal funct3
//   rsp_rdata           extended load data, 0 for stores and errors
//   mem_*               DataMem interface; ReadData is combinational

module load_store_unit #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        mem_WriteEn,
  output logic        mem_ReadEn,
  output logic [31:0] mem_Addr,
  output logic [31:0] mem_WriteData,
  input  logic [31:0] mem_ReadData
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        err_q;

  logic        accept;
  logic        misaligned;
  logic        out_of_range;
  logic        bad_funct3;
  logic        req_err;

  logic [31:0] word_idx;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext;
  logic [31:0] merged;

  assign accept   = req_valid && (state == IDLE);
  assign word_idx = {2'b00, addr_q[31:2]};

  // Decode the incoming request for errors. funct3[1:0] is the access size
  // for both loads and stores; the illegal codes differ between the two.
  always_comb begin
    misaligned = 1'b0;
    case (req_funct3[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
    out_of_range = {2'b00, req_addr[31:2]} >= MEM_WORDS;
    if (req_we) begin
      bad_funct3 = req_funct3 > 3'b010;
    end else begin
      bad_funct3 = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    end
    req_err = misaligned || out_of_range || bad_funct3;
  end

  // Pick the addressed little-endian lane out of the word read from memory
  // and extend it according to the captured funct3.
  always_comb begin
    lane_byte = 8'h00;
    case (addr_q[1:0])
      2'b00:   lane_byte = mem_ReadData[7:0];
      2'b01:   lane_byte = mem_ReadData[15:8];
      2'b10:   lane_byte = mem_ReadData[23:16];
      default: lane_byte = mem_ReadData[31:24];
    endcase
    lane_half = addr_q[1] ? mem_ReadData[31:16] : mem_ReadData[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
      3'b100:  load_ext = {24'h000000, lane_byte};
      3'b101:  load_ext = {16'h0000, lane_half};
      default: load_ext = mem_ReadData;
    endcase
  end

  // Build the word for a sub-word store: the old word with only the
  // addressed lane(s) replaced by the low bits of the store data.
  always_comb begin
    merged = mem_ReadData;
    if (funct3_q[1:0] == 2'b00) begin
      case (addr_q[1:0])
        2'b00:   merged[7:0]   = data_q[7:0];
        2'b01:   merged[15:8]  = data_q[7:0];
        2'b10:   merged[23:16] = data_q[7:0];
        default: merged[31:24] = data_q[7:0];
      endcase
    end else if (funct3_q[1:0] == 2'b01) begin
      if (addr_q[1]) begin
        merged[31:16] = data_q[15:0];
      end else begin
        merged[15:0] = data_q[15:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode. Every output is a pure function of the
  // state and captured request, so the memory enables fall as soon as reset
  // asserts. Word stores skip the read cycle.
  always_comb begin
    state_nxt     = state;
    req_ready     = 1'b0;
    mem_ReadEn    = 1'b0;
    mem_WriteEn   = 1'b0;
    mem_Addr      = 32'h0;
    mem_WriteData = 32'h0;
    rsp_valid     = 1'b0;
    rsp_err       = 1'b0;
    rsp_rdata     = 32'h0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err) begin
            state_nxt = RESP;
          end else if (req_we && (req_funct3 == 3'b010)) begin
            state_nxt = WR;
          end else begin
            state_nxt = RD;
          end
        end
      end
      RD: begin
        mem_ReadEn = 1'b1;
        mem_Addr   = word_idx;
        state_nxt  = we_q ? WR : RESP;
      end
      WR: begin
        mem_WriteEn   = 1'b1;
        mem_Addr      = word_idx;
        mem_WriteData = data_q;
        state_nxt     = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_rdata = (we_q || err_q) ? 32'h0 : data_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture. data_q first holds the store data. In RD it is
  // overwritten with either the extended load result or the merged store
  // word, so one register serves both the response and the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      data_q   <= 32'h0;
      err_q    <= 1'b0;
    end else if (accept) begin
      we_q     <= req_we;
      funct3_q <= req_funct3;
      addr_q   <= req_addr;
      data_q   <= req_wdata;
      err_q    <= req_err;
    end else if (state == RD) begin
      data_q <= we_q ? merged : load_ext;
    end
  end

endmodule
